// File: rtl/bec_slv_pkg.sv
// Shared constants for the BEC slave multiplier: state encoding, field defaults, sizing helper.
// Macro BEC_SLV_DIGIT2_EN selects a 2-bit-per-cycle multiply digit instead of 1.
package bec_slv_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_PROC = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_READ = 3'd4;

  localparam int DEF_M = 163;
  localparam int DEF_W = 32;
  localparam logic [DEF_M-1:0] DEF_POLY = 163'hC9;

`ifdef BEC_SLV_DIGIT2_EN
  localparam int DIGIT = 2;
`else
  localparam int DIGIT = 1;
`endif

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf2m_mul_step.sv
// One combinational step of MSB-first GF(2^M) multiplication, consuming DIGIT bits of B.
// DIGIT=2 is used when BEC_SLV_DIGIT2_EN is defined.
module gf2m_mul_step
  import bec_slv_pkg::*;
#(
  parameter int             M     = DEF_M,
  parameter logic [M-1:0]   POLY  = M'(DEF_POLY),
  parameter int             DIGIT = 1
) (
  input  logic [M-1:0]     a,
  input  logic [DIGIT-1:0] b_bits,
  input  logic [M-1:0]     c_in,
  output logic [M-1:0]     c_out
);

  // Multiply by x modulo f(x): shift, then fold x^M back in as POLY.
  function automatic logic [M-1:0] mulx(input logic [M-1:0] v);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
  endfunction

  generate
    if (DIGIT == 2) begin : g_d2
      assign c_out = mulx(mulx(c_in))
                   ^ (b_bits[1] ? mulx(a) : '0)
                   ^ (b_bits[0] ? a : '0);
    end else begin : g_d1
      assign c_out = mulx(c_in) ^ (b_bits[0] ? a : '0);
    end
  endgenerate

endmodule

// File: rtl/bec_slave_mul.sv
// BEC slave responder: loads two GF(2^M) operands, multiplies mod f(x), streams the product.
// Define BEC_SLV_DIGIT2_EN for 2 bits of B per PROC cycle (same ports and handshake).
module bec_slave_mul
  import bec_slv_pkg::*;
#(
  parameter int           M    = DEF_M,
  parameter logic [M-1:0] POLY = M'(DEF_POLY),
  parameter int           W    = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable_write,
  input  logic         master_ena_proc,
  input  logic         updateRegs,
  input  logic         wr_valid,
  input  logic [W-1:0] wr_data,
  output logic         slv_done,
  output logic         busy,
  output logic         rd_valid,
  output logic [W-1:0] rd_data
);

  localparam int NWORDS = ceil_div(M, W);
  localparam int NSTEPS = ceil_div(M, DIGIT);
  localparam int BEXT_W = NSTEPS * DIGIT;
  localparam int WC_W   = $clog2(2 * NWORDS + 1);
  localparam int RC_W   = $clog2(NWORDS + 1);
  localparam int IW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  logic [2:0]      state;
  logic [M-1:0]    a, b, c, c_next;
  logic [WC_W-1:0] wcnt;
  logic [RC_W-1:0] rcnt;
  logic [IW-1:0]   i;
  logic            full;

  logic [BEXT_W-1:0]   b_ext;
  logic [DIGIT-1:0]    b_dig [NSTEPS];
  logic [NWORDS*W-1:0] c_pad;
  logic [W-1:0]        c_words [NWORDS];

  assign full     = (int'(wcnt) == 2 * NWORDS);
  assign busy     = (state == ST_PROC);
  assign slv_done = (state == ST_DONE);

  // B zero-extended to a whole number of digits, then split so the step counter indexes it directly.
  always_comb begin
    b_ext = '0;
    b_ext[M-1:0] = b;
    for (int k = 0; k < NSTEPS; k++) b_dig[k] = b_ext[k*DIGIT +: DIGIT];
  end

  always_comb begin
    c_pad = '0;
    c_pad[M-1:0] = c;
    for (int k = 0; k < NWORDS; k++) c_words[k] = c_pad[k*W +: W];
  end

  gf2m_mul_step #(.M(M), .POLY(POLY), .DIGIT(DIGIT)) u_step (
    .a      (a),
    .b_bits (b_dig[i]),
    .c_in   (c),
    .c_out  (c_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      a        <= '0;
      b        <= '0;
      c        <= '0;
      wcnt     <= '0;
      rcnt     <= '0;
      i        <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_write) begin
            state <= ST_LOAD;
            wcnt  <= '0;
            a     <= '0;
            b     <= '0;
          end
        end
        ST_LOAD: begin
          if (full && master_ena_proc) begin
            state <= ST_PROC;
            c     <= '0;
            i     <= IW'(NSTEPS - 1);
          end else if (wr_valid && !full) begin
            // Only bits below M have a destination, so top-word excess bits fall away here.
            for (int j = 0; j < M; j++) begin
              if (int'(wcnt) == j / W)          a[j] <= wr_data[j % W];
              if (int'(wcnt) == NWORDS + j / W) b[j] <= wr_data[j % W];
            end
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_PROC: begin
          if (!master_ena_proc) begin
            state <= ST_IDLE;
          end else begin
            c <= c_next;
            if (i == '0) state <= ST_DONE;
            else         i     <= i - 1'b1;
          end
        end
        ST_DONE: begin
          if (updateRegs) begin
            state <= ST_READ;
            rcnt  <= '0;
          end
        end
        ST_READ: begin
          if (int'(rcnt) == NWORDS) begin
            rd_valid <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            rd_valid <= 1'b1;
            rd_data  <= c_words[rcnt];
            rcnt     <= rcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bec_slave_mul.sv
// Directed bench for bec_slave_mul: latency, reduction, load limits, abort, async reset, readout.
module tb_bec_slave_mul;

`ifdef BEC_SLV_DIGIT2_EN
  localparam int LAT = 82;
`else
  localparam int LAT = 163;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_write = 1'b0;
  logic        master_ena_proc = 1'b0;
  logic        updateRegs = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        slv_done, busy, rd_valid;
  logic [31:0] rd_data;

  int checks = 0;
  int failures = 0;

  bec_slave_mul dut (
    .clk             (clk),
    .rst             (rst),
    .enable_write    (enable_write),
    .master_ena_proc (master_ena_proc),
    .updateRegs      (updateRegs),
    .wr_valid        (wr_valid),
    .wr_data         (wr_data),
    .slv_done        (slv_done),
    .busy            (busy),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Enter LOAD and push nw words from a then b (a words first, 6 per operand).
  task automatic load_words(input logic [191:0] av, input logic [191:0] bv, input int nw);
    @(negedge clk) enable_write = 1'b1;
    @(negedge clk) enable_write = 1'b0;
    for (int s = 0; s < nw; s++) begin
      wr_valid = 1'b1;
      wr_data  = (s < 6) ? av[s*32 +: 32] : bv[(s-6)*32 +: 32];
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  // Raise master_ena_proc and measure cycles until slv_done; releases the request afterwards.
  task automatic run_proc(input string tag);
    int cnt;
    master_ena_proc = 1'b1;
    @(negedge clk);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    cnt = 0;
    while (!slv_done && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, cnt, LAT);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    master_ena_proc = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [191:0] expv);
    updateRegs = 1'b1;
    @(negedge clk);
    updateRegs = 1'b0;
    chk({tag, "_done_cleared"}, {31'd0, slv_done}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd1);
      chk({tag, $sformatf("_word%0d", k)}, rd_data, expv[k*32 +: 32]);
    end
    @(negedge clk);
    chk({tag, "_rd_valid_end"}, {31'd0, rd_valid}, 32'd0);
    chk({tag, "_rd_hold"}, rd_data, expv[160 +: 32]);
  endtask

  initial begin
    int seen;
    logic [191:0] av, bv, ev;

    // Reset state
    #1;
    chk("rst_slv_done", {31'd0, slv_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Test 1: 1 * 1
    av = 192'd1; bv = 192'd1; ev = 192'd1;
    load_words(av, bv, 12);
    run_proc("t1");
    read_check("t1", ev);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // Test 2: x^162 * x = x^163 = POLY
    av = 192'd0; av[162] = 1'b1;
    bv = 192'd2; ev = 192'hC9;
    load_words(av, bv, 12);
    run_proc("t2");
    read_check("t2", ev);

    // Test 3: early proc request ignored, top-word excess bits dropped, 13th word ignored
    av = 192'd1; av[160 +: 32] = 32'hFFFF_FFF8;
    bv = 192'd4; ev = 192'd4;
    load_words(av, bv, 7);
    master_ena_proc = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_early_busy", {31'd0, busy}, 32'd0);
    chk("t3_early_done", {31'd0, slv_done}, 32'd0);
    master_ena_proc = 1'b0;
    for (int s = 7; s < 13; s++) begin
      wr_valid = 1'b1;
      wr_data  = (s < 12) ? bv[(s-6)*32 +: 32] : 32'hFFFF_FFFF;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    run_proc("t3");
    read_check("t3", ev);

    // Test 4: abort after 50 PROC cycles, then a clean restart
    load_words(192'd1, 192'd1, 12);
    master_ena_proc = 1'b1;
    @(negedge clk);
    repeat (50) @(negedge clk);
    master_ena_proc = 1'b0;
    @(negedge clk);
    chk("t4_abort_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (slv_done) seen++;
    end
    chk("t4_no_done", seen, 0);
    av = 192'd0; av[161] = 1'b1;
    bv = 192'd2; ev = 192'd0; ev[162] = 1'b1;
    load_words(av, bv, 12);
    run_proc("t4r");
    read_check("t4r", ev);

    // Test 5: asynchronous reset mid-PROC
    load_words(192'd1, 192'd1, 12);
    master_ena_proc = 1'b1;
    @(negedge clk);
    repeat (80) @(negedge clk);
    chk("t5_pre_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    chk("t5_async_done", {31'd0, slv_done}, 32'd0);
    chk("t5_async_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("t5_async_rd_data", rd_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_idle_ignores_proc", {31'd0, busy}, 32'd0);
    master_ena_proc = 1'b0;

    // Test 6: (x+1)^2 = x^2+1 after reset
    load_words(192'd3, 192'd3, 12);
    run_proc("t6");
    read_check("t6", 192'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
